// File: rtl/iob_ram_t2p_fifo_ctrl.sv
// Single-clock FIFO controller driving an external true-2-port RAM with a
// registered 1-cycle read port; owns pointers, level, flags and read-valid.
module iob_ram_t2p_fifo_ctrl #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic [ADDR_W:0] level;
  logic [ADDR_W:0] level_nxt;
  logic            w_acc;
  logic            r_acc;

  // A request is taken in the cycle it is high and the matching flag
  // (full/empty, registered) is low; otherwise it is silently dropped.
  // Read data follows an accepted read by exactly one cycle, marked by r_valid_o.
  assign w_acc = w_en_i & ~w_full_o;
  assign r_acc = r_en_i & ~r_empty_o;

  assign ext_mem_w_en_o   = w_acc;
  assign ext_mem_w_addr_o = wptr[ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = r_acc;
  assign ext_mem_r_addr_o = rptr[ADDR_W-1:0];

  assign r_data_o = ext_mem_r_data_i;
  assign level_o  = level;

  always_comb begin
    level_nxt = level + {{ADDR_W{1'b0}}, w_acc} - {{ADDR_W{1'b0}}, r_acc};
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      r_empty_o <= 1'b1;
      w_full_o  <= 1'b0;
      r_valid_o <= 1'b0;
    end else if (rst_i) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      r_empty_o <= 1'b1;
      w_full_o  <= 1'b0;
      r_valid_o <= 1'b0;
    end else begin
      wptr      <= wptr + {{ADDR_W{1'b0}}, w_acc};
      rptr      <= rptr + {{ADDR_W{1'b0}}, r_acc};
      level     <= level_nxt;
      // Flags come from the next level so they are ready at the start of the next cycle.
      r_empty_o <= (level_nxt == '0);
      w_full_o  <= (level_nxt == DEPTH);
      r_valid_o <= r_acc;
    end
  end

endmodule

// File: tb/tb_iob_ram_t2p_fifo_ctrl.sv
// Bench for iob_ram_t2p_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_iob_ram_t2p_fifo_ctrl;
  localparam int DATA_W = 21;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk_i;
  logic              arst_i;
  logic              rst_i;
  logic              w_en_i;
  logic [DATA_W-1:0] w_data_i;
  logic              w_full_o;
  logic              r_en_i;
  logic [DATA_W-1:0] r_data_o;
  logic              r_valid_o;
  logic              r_empty_o;
  logic [ADDR_W:0]   level_o;
  logic              ext_mem_w_en_o;
  logic [ADDR_W-1:0] ext_mem_w_addr_o;
  logic [DATA_W-1:0] ext_mem_w_data_o;
  logic              ext_mem_r_en_o;
  logic [ADDR_W-1:0] ext_mem_r_addr_o;
  logic [DATA_W-1:0] ext_mem_r_data_i;

  iob_ram_t2p_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .rst_i            (rst_i),
    .w_en_i           (w_en_i),
    .w_data_i         (w_data_i),
    .w_full_o         (w_full_o),
    .r_en_i           (r_en_i),
    .r_data_o         (r_data_o),
    .r_valid_o        (r_valid_o),
    .r_empty_o        (r_empty_o),
    .level_o          (level_o),
    .ext_mem_w_en_o   (ext_mem_w_en_o),
    .ext_mem_w_addr_o (ext_mem_w_addr_o),
    .ext_mem_w_data_o (ext_mem_w_data_o),
    .ext_mem_r_en_o   (ext_mem_r_en_o),
    .ext_mem_r_addr_o (ext_mem_r_addr_o),
    .ext_mem_r_data_i (ext_mem_r_data_i)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // external true-2-port RAM with registered read
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (ext_mem_w_en_o) mem[ext_mem_w_addr_o] <= ext_mem_w_data_o;
    if (ext_mem_r_en_o) ext_mem_r_data_i <= mem[ext_mem_r_addr_o];
  end

  // scoreboard / reference model
  logic [DATA_W-1:0] exp_q[$];
  logic              pend_v;
  logic [DATA_W-1:0] pend_d;
  int                wr_cnt;
  int                rd_cnt;
  int                n_tests;
  int                n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus with full checking
  task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re, input logic rs);
    bit w_acc;
    bit r_acc;
    @(negedge clk_i);
    check("level", 32'(level_o), 32'(exp_q.size()));
    check("empty", 32'(r_empty_o), 32'(exp_q.size() == 0));
    check("full", 32'(w_full_o), 32'(exp_q.size() == DEPTH));
    check("r_valid", 32'(r_valid_o), 32'(pend_v));
    if (pend_v) check("r_data", 32'(r_data_o), 32'(pend_d));
    w_en_i   = we;
    w_data_i = wd;
    r_en_i   = re;
    rst_i    = rs;
    #1;
    w_acc = we && (exp_q.size() < DEPTH);
    r_acc = re && (exp_q.size() != 0);
    check("mem_w_en", 32'(ext_mem_w_en_o), 32'(w_acc));
    if (w_acc) begin
      check("mem_w_addr", 32'(ext_mem_w_addr_o), 32'(wr_cnt % DEPTH));
      check("mem_w_data", 32'(ext_mem_w_data_o), 32'(wd));
    end
    check("mem_r_en", 32'(ext_mem_r_en_o), 32'(r_acc));
    if (r_acc) check("mem_r_addr", 32'(ext_mem_r_addr_o), 32'(rd_cnt % DEPTH));
    if (rs) begin
      exp_q.delete();
      pend_v = 1'b0;
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      pend_v = r_acc;
      if (r_acc) begin
        pend_d = exp_q.pop_front();
        rd_cnt++;
      end
      if (w_acc) begin
        exp_q.push_back(wd);
        wr_cnt++;
      end
    end
    @(posedge clk_i);
    #1;
    w_en_i = 1'b0;
    r_en_i = 1'b0;
    rst_i  = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill_to(input int n);
    while (exp_q.size() < n) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    pend_v   = 1'b0;
    pend_d   = '0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    arst_i   = 1'b0;
    rst_i    = 1'b0;
    w_en_i   = 1'b0;
    r_en_i   = 1'b0;
    w_data_i = '0;

    // asynchronous reset before the first clock edge
    #1 arst_i = 1'b1;
    #1;
    check("rst_empty", 32'(r_empty_o), 32'd1);
    check("rst_full", 32'(w_full_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_valid", 32'(r_valid_o), 32'd0);
    #1 arst_i = 1'b0;

    // fill with 0..15, extra write while full, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    step(1'b1, DATA_W'(21'h1abcd), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("drain_order", 32'(pend_d), 32'(i));
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // interleaved write/read pairs
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end

    // random traffic, biased to sweep the level range
    for (int i = 0; i < 300; i++) begin
      if (i < 150)
        step(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      else
        step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
    end

    // simultaneous read/write at level 5, at full, at empty
    drain();
    fill_to(5);
    for (int i = 0; i < 3; i++) step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    fill_to(DEPTH);
    step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();
    step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // reads on empty are dropped
    drain();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // synchronous reset while a read is accepted at level 7
    drain();
    fill_to(7);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, DATA_W'(21'h0a5a5), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("post_rst_data", 32'(pend_d), 32'h0a5a5);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
